cpu_control_mc: RTL and testbench

CPU_CONTROL_MC -- requirements
Module: cpu_control_mc

---
 rtl/cpu_control_mc.sv | 239 +++++++++++++++++++++++
 tb/tb_cpu_control_mc.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_mc.sv
`default_nettype none
// ============================================================================
// Module   : cpu_control_mc
// Purpose  : Multi-cycle CPU control unit. Sequences each instruction through
//            FETCH, DECODE, EXEC, MEM and WB, generates data-path strobes,
//            counts retired instructions and operand stalls, and halts on a
//            HALT opcode or on a memory handshake timeout.
// Ports    : clk, rst (sync, active-low)
//            opcode/funct        - instruction fields from the data path
//            is_alu_zero         - ALU zero flag (branch resolution)
//            is_full_rnum1/2     - source register busy flags
//            mem_ready           - memory handshake completion
//            mem_req/mem_we      - memory request / write enable
//            is_write_reg, is_write_from_mem, is_load_PC - data-path strobes
//            control_mux_for_PC  - PC source (00 +4, 01 branch, 10 jump)
//            opcode_alu          - ALU operation
//            is_R/I/J_type, is_nop - instruction class flags
//            halted, err         - halt / timeout status
//            retired_cnt, stall_cnt - saturating performance counters
// Revision : 1.0 - initial release
// ============================================================================
module cpu_control_mc #(
    parameter int CNT_WIDTH   = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 is_alu_zero,
    input  logic                 is_full_rnum1,
    input  logic                 is_full_rnum2,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 is_write_reg,
    output logic                 is_write_from_mem,
    output logic                 is_load_PC,
    output logic [1:0]           control_mux_for_PC,
    output logic [5:0]           opcode_alu,
    output logic                 is_R_type,
    output logic                 is_I_type,
    output logic                 is_J_type,
    output logic                 is_nop,
    output logic                 halted,
    output logic                 err,
    output logic [CNT_WIDTH-1:0] retired_cnt,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_op_halt  = 6'b111111;

    localparam logic [5:0] c_alu_add  = 6'b100000;
    localparam logic [5:0] c_alu_sub  = 6'b100010;

    localparam logic [1:0] c_pc_seq   = 2'b00;
    localparam logic [1:0] c_pc_br    = 2'b01;
    localparam logic [1:0] c_pc_jmp   = 2'b10;

    localparam logic [7:0]           c_timeout = 8'(MEM_TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] retired_cnt_q, retired_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [7:0]           wait_q, wait_d;
    logic                 halted_q, halted_d;
    logic                 err_q, err_d;

    logic w_dec_r, w_dec_lw, w_dec_sw, w_dec_addi, w_dec_beq, w_dec_j, w_dec_halt;
    logic w_needs_ops;

    // ------------------------------------------------------------------
    // Instruction decode (purely combinational from opcode/funct)
    // ------------------------------------------------------------------
    always_comb begin
        w_dec_r     = (opcode == c_op_rtype);
        w_dec_lw    = (opcode == c_op_lw);
        w_dec_sw    = (opcode == c_op_sw);
        w_dec_addi  = (opcode == c_op_addi);
        w_dec_beq   = (opcode == c_op_beq);
        w_dec_j     = (opcode == c_op_j);
        w_dec_halt  = (opcode == c_op_halt);
        w_needs_ops = w_dec_r | w_dec_lw | w_dec_sw | w_dec_addi | w_dec_beq;

        is_R_type = w_dec_r;
        is_I_type = w_dec_lw | w_dec_sw | w_dec_addi | w_dec_beq;
        is_J_type = w_dec_j;
        is_nop    = ~(w_needs_ops | w_dec_j | w_dec_halt);

        if (w_dec_r) begin
            opcode_alu = funct;
        end else if (w_dec_lw | w_dec_sw | w_dec_addi) begin
            opcode_alu = c_alu_add;
        end else if (w_dec_beq) begin
            opcode_alu = c_alu_sub;
        end else begin
            opcode_alu = 6'b000000;
        end
    end

    // ------------------------------------------------------------------
    // Next-state, strobe and counter logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d            = state_q;
        retired_cnt_d      = retired_cnt_q;
        stall_cnt_d        = stall_cnt_q;
        wait_d             = 8'd0;
        err_d              = err_q;
        mem_req            = 1'b0;
        mem_we             = 1'b0;
        is_write_reg       = 1'b0;
        is_write_from_mem  = 1'b0;
        is_load_PC         = 1'b0;
        control_mux_for_PC = c_pc_seq;

        case (state_q)
            IDLE: state_d = FETCH;

            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    state_d = DECODE;
                end
            end

            DECODE: begin
                if (w_needs_ops && (is_full_rnum1 || is_full_rnum2)) begin
                    if (stall_cnt_q != '1) begin
                        stall_cnt_d = stall_cnt_q + c_cnt_one;
                    end
                end else if (w_dec_j) begin
                    is_load_PC         = 1'b1;
                    control_mux_for_PC = c_pc_jmp;
                    state_d            = FETCH;
                end else if (w_dec_halt) begin
                    state_d = HALT;
                end else begin
                    state_d = EXEC;
                end
            end

            EXEC: begin
                if (w_dec_r || w_dec_addi) begin
                    state_d = WB;
                end else if (w_dec_lw || w_dec_sw) begin
                    state_d = MEM;
                end else begin
                    // beq and nop both retire here; only a taken beq redirects
                    is_load_PC         = 1'b1;
                    control_mux_for_PC = (w_dec_beq && is_alu_zero) ? c_pc_br : c_pc_seq;
                    state_d            = FETCH;
                end
            end

            MEM: begin
                mem_req = 1'b1;
                mem_we  = w_dec_sw;
                if (mem_ready) begin
                    if (w_dec_lw) begin
                        state_d = WB;
                    end else begin
                        is_load_PC = 1'b1;
                        state_d    = FETCH;
                    end
                end
            end

            WB: begin
                is_write_reg      = 1'b1;
                is_write_from_mem = w_dec_lw;
                is_load_PC        = 1'b1;
                state_d           = FETCH;
            end

            HALT: state_d = HALT;

            default: state_d = IDLE;
        endcase

        // Consecutive unanswered request cycles; mem_ready outside a request
        // never touches the counter because mem_req gates it.
        if (mem_req && !mem_ready) begin
            wait_d = wait_q + 8'd1;
        end
        if (wait_d == c_timeout) begin
            state_d = HALT;
            err_d   = 1'b1;
        end

        if (is_load_PC && (retired_cnt_q != '1)) begin
            retired_cnt_d = retired_cnt_q + c_cnt_one;
        end

        halted_d = (state_d == HALT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            retired_cnt_q <= '0;
            stall_cnt_q   <= '0;
            wait_q        <= 8'd0;
            halted_q      <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            retired_cnt_q <= retired_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            wait_q        <= wait_d;
            halted_q      <= halted_d;
            err_q         <= err_d;
        end
    end

    assign halted      = halted_q;
    assign err         = err_q;
    assign retired_cnt = retired_cnt_q;
    assign stall_cnt   = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_control_mc
// Purpose  : Self-checking bench for cpu_control_mc. Each instruction is
//            described by a transaction (opcode, fetch wait, stall cycles,
//            memory wait, zero flag); a reference model derives latency,
//            strobe counts, PC source and counter values from the rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_control_mc;

    localparam int CNT_W   = 4;
    localparam int TMO     = 15;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [5:0]       opcode = '0, funct = '0;
    logic             is_alu_zero = 1'b0, is_full_rnum1 = 1'b0, is_full_rnum2 = 1'b0;
    logic             mem_ready = 1'b0;
    logic             mem_req, mem_we, is_write_reg, is_write_from_mem, is_load_PC;
    logic [1:0]       control_mux_for_PC;
    logic [5:0]       opcode_alu;
    logic             is_R_type, is_I_type, is_J_type, is_nop, halted, err;
    logic [CNT_W-1:0] retired_cnt, stall_cnt;

    int n_checks = 0;
    int n_fails  = 0;
    int exp_retired = 0;
    int exp_stall   = 0;

    always #5 clk = ~clk;

    cpu_control_mc #(.CNT_WIDTH(CNT_W), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
        .is_alu_zero(is_alu_zero), .is_full_rnum1(is_full_rnum1),
        .is_full_rnum2(is_full_rnum2), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .is_write_reg(is_write_reg),
        .is_write_from_mem(is_write_from_mem), .is_load_PC(is_load_PC),
        .control_mux_for_PC(control_mux_for_PC), .opcode_alu(opcode_alu),
        .is_R_type(is_R_type), .is_I_type(is_I_type), .is_J_type(is_J_type),
        .is_nop(is_nop), .halted(halted), .err(err),
        .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference decode tables: {R, I, J, nop} and ALU operation.
    function automatic logic [3:0] ref_class(input logic [5:0] op);
        case (op)
            OP_R:                          return 4'b1000;
            OP_LW, OP_SW, OP_ADDI, OP_BEQ: return 4'b0100;
            OP_J:                          return 4'b0010;
            OP_HALT:                       return 4'b0000;
            default:                       return 4'b0001;
        endcase
    endfunction

    function automatic logic [5:0] ref_alu(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_R:                  return fn;
            OP_LW, OP_SW, OP_ADDI: return 6'b100000;
            OP_BEQ:                return 6'b100010;
            default:               return 6'b000000;
        endcase
    endfunction

    function automatic int sat_add(input int a, input int b);
        return (a + b > CNT_MAX) ? CNT_MAX : a + b;
    endfunction

    task automatic do_reset();
        rst = 1'b0; mem_ready = 1'b0; opcode = OP_R; funct = '0;
        {is_full_rnum1, is_full_rnum2} = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b1;  // must be ignored in IDLE
        #1;
        chk("idle_outs", {mem_req, mem_we, is_write_reg, is_write_from_mem,
                          is_load_PC, control_mux_for_PC, halted, err}, 32'h0);
        chk("idle_cnts", {retired_cnt, stall_cnt}, 32'h0);
        chk("idle_decode", {is_R_type, is_I_type, is_J_type, is_nop}, 32'h8);
        @(negedge clk);
        exp_retired = 0;
        exp_stall   = 0;
    endtask

    // Runs one instruction starting at the first FETCH cycle; returns at the
    // first cycle of the following FETCH.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                             input int st, input int mw, input logic zr, input string name);
        bit is_r, is_lw, is_sw, is_addi, is_beq, is_j, is_nopi, needs;
        int st_eff, exp_lat, exp_req, exp_we, exp_wr, exp_wfm;
        logic [1:0] exp_mux, got_mux;
        int n_req, n_we, n_wr, n_wfm, n_bad, lat, req_run, fetch_end;
        bit done, fetched;

        is_r = (op == OP_R); is_lw = (op == OP_LW); is_sw = (op == OP_SW);
        is_addi = (op == OP_ADDI); is_beq = (op == OP_BEQ); is_j = (op == OP_J);
        is_nopi = (ref_class(op) == 4'b0001);
        needs   = is_r | is_lw | is_sw | is_addi | is_beq;
        st_eff  = needs ? st : 0;
        exp_lat = (fw + 1) + (st_eff + 1) +
                  (is_j ? 0 : (is_beq || is_nopi) ? 1 : (is_r || is_addi) ? 2 :
                   is_lw ? mw + 3 : mw + 2);
        exp_req = fw + 1 + ((is_lw || is_sw) ? mw + 1 : 0);
        exp_we  = is_sw ? mw + 1 : 0;
        exp_wr  = (is_r || is_addi || is_lw) ? 1 : 0;
        exp_wfm = is_lw ? 1 : 0;
        exp_mux = is_j ? 2'b10 : (is_beq && zr) ? 2'b01 : 2'b00;

        n_req = 0; n_we = 0; n_wr = 0; n_wfm = 0; n_bad = 0; lat = 0;
        req_run = 0; fetch_end = -1; done = 0; fetched = 0; got_mux = 2'b00;
        opcode = op; funct = fn; is_alu_zero = zr;

        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            if (mem_req) begin
                mem_ready = (req_run == (fetched ? mw : fw));
                req_run++;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
                req_run   = 0;
            end
            if (fetched && cyc <= fetch_end + st)
                {is_full_rnum1, is_full_rnum2} = 2'($urandom_range(1, 3));
            else
                {is_full_rnum1, is_full_rnum2} = 2'b00;
            #1;
            if (cyc == 0) begin
                chk({name, "_cls"}, {is_R_type, is_I_type, is_J_type, is_nop}, ref_class(op));
                chk({name, "_alu"}, opcode_alu, ref_alu(op, fn));
            end
            if (mem_req) n_req++;
            if (mem_we) n_we++;
            if (mem_we && !mem_req) n_bad++;
            if (!is_load_PC && control_mux_for_PC != 2'b00) n_bad++;
            if (halted || err) n_bad++;
            if (is_write_reg) n_wr++;
            if (is_write_from_mem) n_wfm++;
            if (mem_req && mem_ready && !fetched) begin
                fetched   = 1;
                fetch_end = cyc;
            end
            if (is_load_PC) begin
                done    = 1;
                lat     = cyc + 1;
                got_mux = control_mux_for_PC;
            end
            @(negedge clk);
        end
        mem_ready = 1'b0;
        {is_full_rnum1, is_full_rnum2} = 2'b00;

        chk({name, "_done"}, done, 1);
        chk({name, "_lat"}, lat, exp_lat);
        chk({name, "_mux"}, got_mux, exp_mux);
        chk({name, "_req"}, n_req, exp_req);
        chk({name, "_we"}, n_we, exp_we);
        chk({name, "_wr"}, {n_wr, n_wfm}, {exp_wr, exp_wfm});
        chk({name, "_bad"}, n_bad, 0);
        exp_retired = sat_add(exp_retired, 1);
        exp_stall   = sat_add(exp_stall, st_eff);
        #1;
        chk({name, "_retired"}, retired_cnt, exp_retired);
        chk({name, "_stall"}, stall_cnt, exp_stall);
        chk({name, "_refetch"}, mem_req, 1);
    endtask

    // Counts request cycles until the block halts on a handshake timeout.
    task automatic wait_timeout(input string name);
        int n;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            mem_ready = 1'b0;
            #1;
            if (halted) break;
            if (mem_req) n++;
            @(negedge clk);
        end
        chk({name, "_cycles"}, n, TMO);
        chk({name, "_state"}, {halted, err, mem_req}, 3'b110);
    endtask

    initial begin
        int bad;
        logic [5:0] op;

        // Directed scenarios
        do_reset();
        run_instr(OP_R,    6'b100000, 0, 0, 0, 1'b0, "add");
        run_instr(OP_LW,   6'h15,     0, 0, 3, 1'b0, "lw_w3");
        run_instr(OP_BEQ,  6'h00,     0, 0, 0, 1'b1, "beq_t");
        run_instr(OP_BEQ,  6'h00,     0, 0, 0, 1'b0, "beq_nt");
        run_instr(OP_ADDI, 6'h00,     0, 5, 0, 1'b0, "addi_st5");
        run_instr(OP_SW,   6'h00,     2, 1, 2, 1'b1, "sw");
        run_instr(OP_J,    6'h00,     1, 2, 0, 1'b0, "j_busy");
        run_instr(6'b010101, 6'h00,   0, 2, 0, 1'b1, "nop_busy");
        run_instr(OP_ADDI, 6'h00,    14, 0, 0, 1'b0, "fetch_w14");
        run_instr(OP_LW,   6'h00,     0, 0, 14, 1'b0, "mem_w14");

        // HALT opcode: absorbing, counters frozen
        opcode = OP_HALT; mem_ready = 1'b1; #1;
        chk("halt_cls", {is_R_type, is_I_type, is_J_type, is_nop}, 4'b0000);
        @(negedge clk);
        mem_ready = 1'b0; #1;
        chk("halt_decode", halted, 1'b0);
        @(negedge clk);
        #1;
        chk("halt_entry", {halted, err}, 2'b10);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            {is_full_rnum1, is_full_rnum2} = 2'($urandom_range(0, 3));
            opcode = 6'($urandom);
            #1;
            if ({mem_req, mem_we, is_write_reg, is_write_from_mem, is_load_PC,
                 control_mux_for_PC} != 7'b0) bad++;
            if (!halted || err) bad++;
            if (retired_cnt != CNT_W'(exp_retired) || stall_cnt != CNT_W'(exp_stall)) bad++;
            @(negedge clk);
        end
        chk("halt_absorb", bad, 0);

        // Timeout while fetching
        do_reset();
        wait_timeout("tmo_fetch");
        chk("tmo_fetch_cnt", retired_cnt, 0);

        // Timeout in MEM after a completed fetch
        do_reset();
        opcode = OP_LW; mem_ready = 1'b1;
        @(negedge clk);
        wait_timeout("tmo_mem");

        // Reset in the middle of a memory handshake
        do_reset();
        run_instr(OP_R, 6'b100010, 0, 2, 0, 1'b0, "sub_st2");
        opcode = OP_LW; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("mem_before_rst", {mem_req, mem_we}, 2'b10);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_mid_outs", {mem_req, mem_we, is_load_PC, halted, err}, 5'b0);
        chk("rst_mid_cnts", {retired_cnt, stall_cnt}, 8'h00);

        // Randomised instruction stream (long enough to saturate counters)
        do_reset();
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 6))
                0: op = OP_R;
                1: op = OP_LW;
                2: op = OP_SW;
                3: op = OP_ADDI;
                4: op = OP_BEQ;
                5: op = OP_J;
                default: begin
                    op = 6'b010101;
                    for (int t = 0; t < 50; t++) begin
                        op = 6'($urandom);
                        if (ref_class(op) == 4'b0001) break;
                    end
                    if (ref_class(op) != 4'b0001) op = 6'b010101;
                end
            endcase
            run_instr(op, 6'($urandom), $urandom_range(0, 3), $urandom_range(0, 2),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
